lsu: RTL and testbench

- Load/store unit on the consuming side of the execute stage.
- Takes the ALU-computed effective address, store data and access type, and drives a valid/ready request and response data-memory port.
- Returns aligned, extended load data (or a store completion) to writeback as a one-cycle done pulse.
- Holds the pipeline, via lsu_ready, while an access is outstanding.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu.sv | 112 +++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type encodings,
// byte-strobe constants and the control FSM state type.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_DRAIN
   } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Valid/ready data-memory port: request channel out of the LSU, response
// channel back in. The LSU is the master side.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_W-1:0]     mem_req_addr;
   logic                  mem_req_we;
   logic [DATA_W-1:0]     mem_req_wdata;
   logic [DATA_W/8-1:0]   mem_req_wstrb;
   logic                  mem_rsp_valid;
   logic [DATA_W-1:0]     mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes and access legality on
// the request side, byte/half select with sign/zero extension on the response side.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [2:0]  rsp_funct3,
   input  logic [1:0]  rsp_off,
   input  logic [31:0] rdata,
   output logic [31:0] store_data,
   output logic [3:0]  store_strb,
   output logic        err,
   output logic [31:0] load_data
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
      store_data = wdata;
      store_strb = STRB_NONE;
      err        = 1'b0;
      if (we) begin
         case (funct3)
            F3_SB: begin
               store_data = {4{wdata[7:0]}};
               store_strb = STRB_B << off;
            end
            F3_SH: begin
               store_data = {2{wdata[15:0]}};
               store_strb = STRB_H << off;
               err        = off[0];
            end
            F3_SW: begin
               store_strb = STRB_W;
               err        = |off;
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: err = 1'b0;
            F3_LH, F3_LHU: err = off[0];
            F3_LW:         err = |off;
            default:       err = 1'b1;
         endcase
      end
   end

   always_comb begin
      shifted   = rdata >> {rsp_off, 3'b000};
      byte_sel  = shifted[7:0];
      half_sel  = rsp_off[1] ? rdata[31:16] : rdata[15:0];
      load_data = '0;
      case (rsp_funct3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  load_data = {24'b0, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  load_data = {16'b0, half_sel};
         F3_LW:   load_data = rdata;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, runs it over the
// valid/ready memory port and returns a one-cycle done pulse to writeback.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_funct3,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic              flush,
   lsu_if.master             mem,
   output logic              done_valid,
   output logic [DATA_W-1:0] done_data,
   output logic              done_err
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_we_q;
   logic [31:0]       req_wdata_q;
   logic [3:0]        req_strb_q;
   logic [2:0]        op_funct3_q;
   logic [1:0]        op_off_q;
   logic [31:0]       done_data_q;
   logic              done_err_q;

   logic [31:0] store_data, load_data;
   logic [3:0]  store_strb;
   logic        align_err;
   logic        accept, rsp_take;

   lsu_align u_align (
      .we         (lsu_we),
      .funct3     (lsu_funct3),
      .off        (lsu_addr[1:0]),
      .wdata      (lsu_wdata),
      .rsp_funct3 (op_funct3_q),
      .rsp_off    (op_off_q),
      .rdata      (mem.mem_rsp_rdata),
      .store_data (store_data),
      .store_strb (store_strb),
      .err        (align_err),
      .load_data  (load_data)
   );

   assign accept   = (state_q == ST_IDLE) && lsu_valid && !flush;
   assign rsp_take = (state_q == ST_WAIT) && mem.mem_rsp_valid && !flush;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = align_err ? ST_DONE : ST_REQ;
         // A flush on the handshake cycle still leaves a response owed by memory.
         ST_REQ:   if (flush) state_d = mem.mem_req_ready ? ST_DRAIN : ST_IDLE;
                   else if (mem.mem_req_ready) state_d = ST_WAIT;
         ST_WAIT:  if (flush) state_d = mem.mem_rsp_valid ? ST_IDLE : ST_DRAIN;
                   else if (mem.mem_rsp_valid) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_DRAIN: if (mem.mem_rsp_valid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wdata_q <= '0;
         req_strb_q  <= STRB_NONE;
         op_funct3_q <= '0;
         op_off_q    <= '0;
         done_data_q <= '0;
         done_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            req_addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
            req_we_q    <= lsu_we;
            req_wdata_q <= store_data;
            req_strb_q  <= lsu_we ? store_strb : STRB_NONE;
            op_funct3_q <= lsu_funct3;
            op_off_q    <= lsu_addr[1:0];
            done_data_q <= '0;
            done_err_q  <= align_err;
         end
         if (rsp_take) done_data_q <= req_we_q ? '0 : load_data;
      end
   end

   assign lsu_ready         = (state_q == ST_IDLE);
   assign mem.mem_req_valid = (state_q == ST_REQ);
   assign mem.mem_req_addr  = req_addr_q;
   assign mem.mem_req_we    = req_we_q;
   assign mem.mem_req_wdata = req_wdata_q;
   assign mem.mem_req_wstrb = req_strb_q;
   assign done_valid        = (state_q == ST_DONE) && !flush;
   assign done_data         = done_data_q;
   assign done_err          = done_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads/stores through the memory port, error paths,
// back-pressure, flush in each state and asynchronous reset mid-request.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic        lsu_we = 1'b0;
   logic [2:0]  lsu_funct3 = 3'b000;
   logic [31:0] lsu_addr = '0;
   logic [31:0] lsu_wdata = '0;
   logic        flush = 1'b0;
   logic        done_valid;
   logic [31:0] done_data;
   logic        done_err;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   lsu_if #(.ADDR_W(32), .DATA_W(32)) mem ();

   lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_we     (lsu_we),
      .lsu_funct3 (lsu_funct3),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .flush      (flush),
      .mem        (mem),
      .done_valid (done_valid),
      .done_data  (done_data),
      .done_err   (done_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
      lsu_valid  = 1'b1;
      lsu_we     = we;
      lsu_funct3 = f3;
      lsu_addr   = addr;
      lsu_wdata  = wdata;
   endtask

   // Accept at cycle 0, request at 1, response at 2, done at 3.
   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_strb, input logic [31:0] exp_data);
      mem.mem_req_ready = 1'b1;
      present(we, f3, addr, wdata);
      check1({tag, "/ready_idle"}, lsu_ready, 1'b1);
      tick();
      lsu_valid = 1'b0;
      check1({tag, "/req_valid"}, mem.mem_req_valid, 1'b1);
      check ({tag, "/req_addr"}, mem.mem_req_addr, exp_addr);
      check1({tag, "/req_we"}, mem.mem_req_we, we);
      check ({tag, "/req_wdata"}, mem.mem_req_wdata, exp_wdata);
      check ({tag, "/req_wstrb"}, 32'(mem.mem_req_wstrb), 32'(exp_strb));
      check1({tag, "/ready_busy"}, lsu_ready, 1'b0);
      tick();
      mem.mem_rsp_valid = 1'b1;
      mem.mem_rsp_rdata = rdata;
      check1({tag, "/wait_nodone"}, done_valid, 1'b0);
      check1({tag, "/wait_noreq"}, mem.mem_req_valid, 1'b0);
      tick();
      mem.mem_rsp_valid = 1'b0;
      check1({tag, "/done_valid"}, done_valid, 1'b1);
      check ({tag, "/done_data"}, done_data, exp_data);
      check1({tag, "/done_err"}, done_err, 1'b0);
      tick();
      check1({tag, "/done_once"}, done_valid, 1'b0);
      check1({tag, "/ready_back"}, lsu_ready, 1'b1);
   endtask

   // Error ops finish at cycle 1 and never raise a request.
   task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
      mem.mem_req_ready = 1'b1;
      present(we, f3, addr, 32'h1234_5678);
      tick();
      lsu_valid = 1'b0;
      check1({tag, "/done_valid"}, done_valid, 1'b1);
      check1({tag, "/done_err"}, done_err, 1'b1);
      check ({tag, "/done_data"}, done_data, 32'h0);
      check1({tag, "/no_req"}, mem.mem_req_valid, 1'b0);
      tick();
      check1({tag, "/done_once"}, done_valid, 1'b0);
      check1({tag, "/no_req2"}, mem.mem_req_valid, 1'b0);
      check1({tag, "/ready_back"}, lsu_ready, 1'b1);
   endtask

   initial begin
      mem.mem_req_ready = 1'b0;
      mem.mem_rsp_valid = 1'b0;
      mem.mem_rsp_rdata = '0;

      // Reset values
      #12;
      check1("rst/lsu_ready", lsu_ready, 1'b1);
      check1("rst/req_valid", mem.mem_req_valid, 1'b0);
      check ("rst/req_addr", mem.mem_req_addr, 32'h0);
      check1("rst/req_we", mem.mem_req_we, 1'b0);
      check ("rst/req_wdata", mem.mem_req_wdata, 32'h0);
      check ("rst/req_wstrb", 32'(mem.mem_req_wstrb), 32'h0);
      check1("rst/done_valid", done_valid, 1'b0);
      check ("rst/done_data", done_data, 32'h0);
      check1("rst/done_err", done_err, 1'b0);
      rst_n = 1'b1;
      tick();

      // Loads: word, signed/unsigned byte and half
      run_op("lw",     1'b0, F3_LW,  32'h100, 32'h0, 32'hDEAD_BEEF, 32'h100, 32'h0, 4'b0000, 32'hDEAD_BEEF);
      run_op("lb3",    1'b0, F3_LB,  32'h203, 32'h0, 32'h80FF_1234, 32'h200, 32'h0, 4'b0000, 32'hFFFF_FF80);
      run_op("lbu3",   1'b0, F3_LBU, 32'h203, 32'h0, 32'h80FF_1234, 32'h200, 32'h0, 4'b0000, 32'h0000_0080);
      run_op("lh2",    1'b0, F3_LH,  32'h202, 32'h0, 32'h80FF_1234, 32'h200, 32'h0, 4'b0000, 32'hFFFF_80FF);
      run_op("lhu2",   1'b0, F3_LHU, 32'h202, 32'h0, 32'h80FF_1234, 32'h200, 32'h0, 4'b0000, 32'h0000_80FF);
      run_op("lb1",    1'b0, F3_LB,  32'h201, 32'h0, 32'h80FF_1234, 32'h200, 32'h0, 4'b0000, 32'h0000_0012);
      run_op("lh0",    1'b0, F3_LH,  32'h200, 32'h0, 32'h80FF_9234, 32'h200, 32'h0, 4'b0000, 32'hFFFF_9234);

      // Stores: lane replication and strobes
      run_op("sh2",    1'b1, F3_SH,  32'h302, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'h300, 32'hABCD_ABCD, 4'b1100, 32'h0);
      run_op("sb1",    1'b1, F3_SB,  32'h401, 32'h1234_565A, 32'hFFFF_FFFF, 32'h400, 32'h5A5A_5A5A, 4'b0010, 32'h0);
      run_op("sw0",    1'b1, F3_SW,  32'h500, 32'h1234_5678, 32'hFFFF_FFFF, 32'h500, 32'h1234_5678, 4'b1111, 32'h0);

      // Misaligned and illegal encodings
      run_err("lw_mis",  1'b0, F3_LW,  32'h101);
      run_err("lh_mis",  1'b0, F3_LH,  32'h203);
      run_err("f3_011",  1'b0, 3'b011, 32'h100);
      run_err("st_f3_4", 1'b1, 3'b100, 32'h100);

      // Back-pressure: payload stable, extra lsu_valid ignored
      mem.mem_req_ready = 1'b0;
      present(1'b0, F3_LW, 32'h600, 32'h0);
      tick();
      present(1'b1, F3_SW, 32'h704, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) begin
         check1("stall/req_valid", mem.mem_req_valid, 1'b1);
         check ("stall/req_addr", mem.mem_req_addr, 32'h600);
         check1("stall/req_we", mem.mem_req_we, 1'b0);
         check ("stall/req_wstrb", 32'(mem.mem_req_wstrb), 32'h0);
         check1("stall/lsu_ready", lsu_ready, 1'b0);
         tick();
      end
      lsu_valid = 1'b0;
      mem.mem_req_ready = 1'b1;
      tick();
      check1("stall/req_drop", mem.mem_req_valid, 1'b0);
      mem.mem_rsp_valid = 1'b1;
      mem.mem_rsp_rdata = 32'h1122_3344;
      tick();
      mem.mem_rsp_valid = 1'b0;
      check1("stall/done_valid", done_valid, 1'b1);
      check ("stall/done_data", done_data, 32'h1122_3344);
      tick();

      // Response while idle is ignored
      mem.mem_rsp_valid = 1'b1;
      tick();
      mem.mem_rsp_valid = 1'b0;
      check1("idle_rsp/done_valid", done_valid, 1'b0);
      check1("idle_rsp/lsu_ready", lsu_ready, 1'b1);

      // Flush in WAIT, response two cycles later
      present(1'b0, F3_LW, 32'h800, 32'h0);
      tick();
      lsu_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check1("flush_wait/drain_busy", lsu_ready, 1'b0);
      check1("flush_wait/no_done1", done_valid, 1'b0);
      tick();
      check1("flush_wait/no_done2", done_valid, 1'b0);
      check1("flush_wait/still_busy", lsu_ready, 1'b0);
      mem.mem_rsp_valid = 1'b1;
      tick();
      mem.mem_rsp_valid = 1'b0;
      check1("flush_wait/ready_back", lsu_ready, 1'b1);
      check1("flush_wait/no_done3", done_valid, 1'b0);

      // Flush in REQ without handshake returns straight to IDLE
      mem.mem_req_ready = 1'b0;
      present(1'b0, F3_LW, 32'h900, 32'h0);
      tick();
      lsu_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check1("flush_req/ready", lsu_ready, 1'b1);
      check1("flush_req/req_valid", mem.mem_req_valid, 1'b0);

      // Flush on the handshake cycle drains the owed response
      mem.mem_req_ready = 1'b1;
      present(1'b0, F3_LW, 32'hA00, 32'h0);
      tick();
      lsu_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check1("flush_hs/drain_busy", lsu_ready, 1'b0);
      check1("flush_hs/req_valid", mem.mem_req_valid, 1'b0);
      mem.mem_rsp_valid = 1'b1;
      tick();
      mem.mem_rsp_valid = 1'b0;
      check1("flush_hs/ready_back", lsu_ready, 1'b1);
      check1("flush_hs/no_done", done_valid, 1'b0);

      // Flush in DONE suppresses the pulse
      present(1'b0, F3_LW, 32'h102, 32'h0);
      tick();
      lsu_valid = 1'b0;
      check1("flush_done/pre", done_valid, 1'b1);
      flush = 1'b1;
      #1;
      check1("flush_done/suppressed", done_valid, 1'b0);
      tick();
      flush = 1'b0;
      check1("flush_done/ready", lsu_ready, 1'b1);

      // Flush in IDLE drops a simultaneous op
      present(1'b0, F3_LW, 32'hB00, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      lsu_valid = 1'b0;
      check1("flush_idle/ready", lsu_ready, 1'b1);
      check1("flush_idle/no_req", mem.mem_req_valid, 1'b0);
      check1("flush_idle/no_done", done_valid, 1'b0);

      // Asynchronous reset while a request is pending
      mem.mem_req_ready = 1'b0;
      present(1'b1, F3_SW, 32'hC00, 32'h5555_AAAA);
      tick();
      lsu_valid = 1'b0;
      check1("rst_req/pre", mem.mem_req_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check1("rst_req/req_valid", mem.mem_req_valid, 1'b0);
      check ("rst_req/req_addr", mem.mem_req_addr, 32'h0);
      check1("rst_req/req_we", mem.mem_req_we, 1'b0);
      check ("rst_req/req_wdata", mem.mem_req_wdata, 32'h0);
      check ("rst_req/req_wstrb", 32'(mem.mem_req_wstrb), 32'h0);
      check1("rst_req/lsu_ready", lsu_ready, 1'b1);
      check1("rst_req/done_valid", done_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check1("rst_req/ready_after", lsu_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
